// File: rtl/passcode_lock_ctrl_pkg.sv
// Shared definitions for the keypad lock: state encodings, code length and
// the digit type, plus a helper that packs buffered digits into a 16-bit code.
package lock_pkg;

  localparam logic [1:0] ST_INITIAL  = 2'b00;
  localparam logic [1:0] ST_UNLOCKED = 2'b01;
  localparam logic [1:0] ST_LOCKED   = 2'b10;

  localparam int CODE_DIGITS = 4;

  // Segment-driver code for an unlit digit position.
  localparam logic [4:0] BLANK_DIGIT = 5'b10100;

  typedef logic [3:0] digit_t;

  // First-entered digit lands in the most significant nibble.
  function automatic logic [15:0] pack_code(digit_t d1, digit_t d2, digit_t d3, digit_t d4);
    return {d1, d2, d3, d4};
  endfunction

endpackage

// File: rtl/passcode_lock_ctrl_if.sv
// Keypad strobes in, display-facing lock status out.
interface passcode_lock_ctrl_if;
  // Strobes are single-cycle valids with no ready: the controller always
  // accepts, honouring one per cycle by priority clear > lock > enter > digit.
  logic       digit_valid;
  logic [3:0] digit;
  logic       enter;
  logic       lock;
  logic       clear;

  logic [3:0] hex1;
  logic [3:0] hex2;
  logic [3:0] hex3;
  logic [3:0] hex4;
  logic [2:0] counter;
  logic [1:0] state;
  logic       fail;
  logic       lockout;

  modport master (
    output digit_valid, digit, enter, lock, clear,
    input  hex1, hex2, hex3, hex4, counter, state, fail, lockout
  );

  modport slave (
    input  digit_valid, digit, enter, lock, clear,
    output hex1, hex2, hex3, hex4, counter, state, fail, lockout
  );
endinterface

// File: rtl/passcode_lock_ctrl_lockout_timer.sv
// Load/count-down timer holding busy high for exactly CYCLES clocks after load.
// Only built when LOCKOUT_EN is defined.
`ifdef LOCKOUT_EN
module lockout_timer #(
    parameter int CYCLES = 100_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic busy
);
    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] remaining_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            remaining_q <= '0;
        end else if (load) begin
            busy        <= 1'b1;
            remaining_q <= W'(CYCLES - 1);
        end else if (busy) begin
            if (remaining_q == '0) busy <= 1'b0;
            else                   remaining_q <= remaining_q - W'(1);
        end
    end
endmodule
`endif

// File: rtl/passcode_lock_ctrl.sv
// Passcode entry and lock-state controller feeding the seven-segment driver.
// Define LOCKOUT_EN to build the fail counter and lockout timer.
module passcode_lock_ctrl
  import lock_pkg::*;
#(
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 100_000_000
) (
  input logic                 clock,
  input logic                 reset,
  passcode_lock_ctrl_if.slave bus
);

  localparam logic [2:0] FULL = 3'(CODE_DIGITS);

  logic [1:0]  state_q;
  digit_t      hex_q [CODE_DIGITS];
  logic [2:0]  count_q;
  logic [15:0] code_q;
  logic        fail_q;
  logic        locked_out;

  logic        take_clear, take_lock, take_enter, take_digit;
  logic [15:0] entered;
  logic        code_match;

  // A higher-priority strobe swallows the cycle even when it is itself ignored.
  always_comb begin
    entered    = pack_code(hex_q[0], hex_q[1], hex_q[2], hex_q[3]);
    code_match = (entered == code_q);
    take_clear = !locked_out && bus.clear;
    take_lock  = !locked_out && !bus.clear && bus.lock && (state_q == ST_UNLOCKED);
    take_enter = !locked_out && !bus.clear && !bus.lock && bus.enter && (count_q == FULL);
    take_digit = !locked_out && !bus.clear && !bus.lock && !bus.enter &&
                 bus.digit_valid && (count_q < FULL);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_INITIAL;
      count_q <= '0;
      code_q  <= '0;
      fail_q  <= 1'b0;
      for (int i = 0; i < CODE_DIGITS; i++) hex_q[i] <= '0;
    end else begin
      fail_q <= 1'b0;
      if (take_clear || take_lock || take_enter) begin
        count_q <= '0;
        for (int i = 0; i < CODE_DIGITS; i++) hex_q[i] <= '0;
      end
      if (take_lock) state_q <= ST_LOCKED;
      if (take_enter) begin
        case (state_q)
          ST_INITIAL: begin
            code_q  <= entered;
            state_q <= ST_LOCKED;
          end
          ST_LOCKED: begin
            if (code_match) state_q <= ST_UNLOCKED;
            else            fail_q  <= 1'b1;
          end
          ST_UNLOCKED: code_q  <= entered;
          default:     state_q <= ST_INITIAL;
        endcase
      end
      if (take_digit) begin
        hex_q[count_q[1:0]] <= bus.digit;
        count_q             <= count_q + 3'd1;
      end
    end
  end

`ifdef LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAILS + 1);

  logic [FW-1:0] fails_q;
  logic          bad_try;
  logic          trip;

  assign bad_try = take_enter && (state_q == ST_LOCKED) && !code_match;
  assign trip    = bad_try && (fails_q == FW'(MAX_FAILS - 1));

  // The count restarts when the lockout begins; strobes are ignored until it ends.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                                   fails_q <= '0;
    else if (trip)                                               fails_q <= '0;
    else if (take_enter && (state_q == ST_LOCKED) && code_match) fails_q <= '0;
    else if (bad_try && (fails_q != FW'(MAX_FAILS)))             fails_q <= fails_q + FW'(1);
  end

  lockout_timer #(
    .CYCLES(LOCKOUT_CYCLES)
  ) u_lockout_timer (
    .clock(clock),
    .reset(reset),
    .load (trip),
    .busy (locked_out)
  );
`else
  assign locked_out = 1'b0;
`endif

  assign bus.hex1    = hex_q[0];
  assign bus.hex2    = hex_q[1];
  assign bus.hex3    = hex_q[2];
  assign bus.hex4    = hex_q[3];
  assign bus.counter = count_q;
  assign bus.state   = state_q;
  assign bus.fail    = fail_q;
  assign bus.lockout = locked_out;

endmodule

// File: tb/tb_passcode_lock_ctrl.sv
// Bench for passcode_lock_ctrl: directed test-plan steps then random strobes,
// every cycle compared against a digit-queue reference model.
module tb_passcode_lock_ctrl;
  import lock_pkg::*;

  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 20;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  passcode_lock_ctrl_if bus();

  passcode_lock_ctrl #(
    .MAX_FAILS(MAX_FAILS),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  // reference model
  logic [3:0]  m_buf[$];
  logic [1:0]  m_state;
  logic [15:0] m_pass;
  logic        m_fail;
  int          m_fails;
  int          m_left;

  task automatic model_reset();
    m_buf.delete();
    m_state = ST_INITIAL;
    m_pass  = 16'h0000;
    m_fail  = 1'b0;
    m_fails = 0;
    m_left  = 0;
  endtask

  task automatic model_step(input bit dv, input logic [3:0] d, input bit en, input bit lk, input bit cl);
    logic [15:0] code;
    m_fail = 1'b0;
    if (m_left > 0) begin
      m_left--;
      return;
    end
    if (cl) m_buf.delete();
    else if (lk) begin
      if (m_state == ST_UNLOCKED) begin
        m_state = ST_LOCKED;
        m_buf.delete();
      end
    end else if (en) begin
      if (m_buf.size() == 4) begin
        code = 16'(m_buf[0]) * 16'd4096 + 16'(m_buf[1]) * 16'd256 + 16'(m_buf[2]) * 16'd16 + 16'(m_buf[3]);
        if (m_state == ST_INITIAL) begin
          m_pass  = code;
          m_state = ST_LOCKED;
        end else if (m_state == ST_UNLOCKED) begin
          m_pass = code;
        end else if (code == m_pass) begin
          m_state = ST_UNLOCKED;
          m_fails = 0;
        end else begin
          m_fail = 1'b1;
          m_fails++;
`ifdef LOCKOUT_EN
          if (m_fails >= MAX_FAILS) begin
            m_left  = LOCKOUT_CYCLES;
            m_fails = 0;
          end
`endif
        end
        m_buf.delete();
      end
    end else if (dv && m_buf.size() < 4) begin
      m_buf.push_back(d);
    end
  endtask

  function automatic logic [3:0] digit_of(input logic [15:0] c, input int i);
    return c[15-4*i -: 4];
  endfunction

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] eh[4];
    for (int i = 0; i < 4; i++) eh[i] = (i < m_buf.size()) ? m_buf[i] : 4'h0;
    check("hex1",    32'(bus.hex1),    32'(eh[0]));
    check("hex2",    32'(bus.hex2),    32'(eh[1]));
    check("hex3",    32'(bus.hex3),    32'(eh[2]));
    check("hex4",    32'(bus.hex4),    32'(eh[3]));
    check("counter", 32'(bus.counter), 32'(m_buf.size()));
    check("state",   32'(bus.state),   32'(m_state));
    check("fail",    32'(bus.fail),    32'(m_fail));
    check("lockout", 32'(bus.lockout), 32'(m_left > 0));
  endtask

  // drivers
  task automatic cycle(input bit dv, input logic [3:0] d, input bit en, input bit lk, input bit cl);
    @(negedge clock);
    bus.digit_valid = dv;
    bus.digit       = d;
    bus.enter       = en;
    bus.lock        = lk;
    bus.clear       = cl;
    model_step(dv, d, en, lk, cl);
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic idle();           cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0); endtask
  task automatic key(input logic [3:0] d); cycle(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
  task automatic press_enter();    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0); endtask
  task automatic press_lock();     cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0); endtask
  task automatic press_clear();    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1); endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 0; i < 4; i++) key(digit_of(c, i));
    press_enter();
  endtask

  initial begin
    int r;
    bit dv, en, lk, cl;

    bus.digit_valid = 1'b0;
    bus.digit       = 4'h0;
    bus.enter       = 1'b0;
    bus.lock        = 1'b0;
    bus.clear       = 1'b0;
    reset           = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all();
    check("rst_state",   32'(bus.state),   32'(2'b00));
    check("rst_counter", 32'(bus.counter), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // digits count up, then enter programs and locks
    for (int i = 1; i <= 4; i++) begin
      key(4'(i));
      check("tp1_counter", 32'(bus.counter), 32'(i));
    end
    press_enter();
    check("tp1_state",   32'(bus.state),   32'(2'b10));
    check("tp1_counter", 32'(bus.counter), 32'd0);
    check("tp1_hex1",    32'(bus.hex1),    32'd0);

    // correct code unlocks, lock relocks
    enter_code(16'h1234);
    check("tp2_state", 32'(bus.state), 32'(2'b01));
    check("tp2_fail",  32'(bus.fail),  32'd0);
    press_lock();
    check("tp2_lock",  32'(bus.state), 32'(2'b10));

    // reversed code: one-cycle fail pulse
    enter_code(16'h4321);
    check("tp3_fail",    32'(bus.fail),    32'd1);
    check("tp3_state",   32'(bus.state),   32'(2'b10));
    check("tp3_counter", 32'(bus.counter), 32'd0);
    idle();
    check("tp3_fail_end", 32'(bus.fail), 32'd0);

    // fifth digit ignored, short enter ignored, clear beats digit
    for (int i = 1; i <= 5; i++) key(4'(i));
    check("tp4_counter", 32'(bus.counter), 32'd4);
    check("tp4_hex4",    32'(bus.hex4),    32'd4);
    press_clear();
    for (int i = 1; i <= 3; i++) key(4'(i));
    press_enter();
    check("tp4_short_state", 32'(bus.state),   32'(2'b10));
    check("tp4_short_count", 32'(bus.counter), 32'd3);
    cycle(1'b1, 4'h7, 1'b0, 1'b0, 1'b1);
    check("tp4_clr_digit", 32'(bus.counter), 32'd0);

    enter_code(16'h1234);
    press_lock();

    // three consecutive mismatches
    for (int k = 0; k < 3; k++) enter_code(16'h9999);
`ifdef LOCKOUT_EN
    check("tp5_lockout_on", 32'(bus.lockout), 32'd1);
    check("tp5_last_fail",  32'(bus.fail),    32'd1);
    enter_code(16'h1234);
    check("tp5_ignored_state", 32'(bus.state),   32'(2'b10));
    check("tp5_ignored_count", 32'(bus.counter), 32'd0);
    for (int k = 0; k < 3 * LOCKOUT_CYCLES && bus.lockout; k++) idle();
    check("tp5_lockout_off", 32'(bus.lockout), 32'd0);
`else
    check("tp5_no_lockout", 32'(bus.lockout), 32'd0);
`endif
    enter_code(16'h1234);
    check("tp5_unlock", 32'(bus.state), 32'(2'b01));

    // async reset mid-entry while unlocked
    key(4'h5);
    key(4'h6);
    check("tp6_counter", 32'(bus.counter), 32'd2);
    @(negedge clock);
    bus.digit_valid = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    check("tp6_rst_state", 32'(bus.state),   32'(2'b00));
    check("tp6_rst_count", 32'(bus.counter), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    enter_code(16'h0000);
    check("tp6_prog", 32'(bus.state), 32'(2'b10));
    enter_code(16'h0000);
    check("tp6_zero_unlock", 32'(bus.state), 32'(2'b01));

    // random strobes, with occasional correct-code bursts
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        press_clear();
        enter_code(m_pass);
      end else begin
        dv = ($urandom_range(0, 99) < 55);
        en = ($urandom_range(0, 99) < 20);
        lk = ($urandom_range(0, 99) < 8);
        cl = ($urandom_range(0, 99) < 5);
        cycle(dv, 4'($urandom_range(0, 15)), en, lk, cl);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/passcode_lock_ctrl.md
# passcode_lock_ctrl

Passcode entry and lock-state controller for the keypad lock. Collects up to four hex digits from the debounced keypad, programs and checks a 4-digit passcode, and tracks the INITIAL/LOCKED/UNLOCKED state. Sits directly upstream of the seven-segment display driver and feeds it `hex1`–`hex4`, `counter` (digits entered) and `state`.

## Interface
- `MAX_FAILS`, 3: consecutive mismatches that trigger lockout (used only with `LOCKOUT_EN`).
- `LOCKOUT_CYCLES`, 100_000_000: lockout duration in `clock` cycles (used only with `LOCKOUT_EN`).
- `clock`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `digit_valid`  in  1  one-cycle strobe: `digit` holds a keypad value.
- `digit`  in  4  hex digit, 0x0–0xF.
- `enter`  in  1  one-cycle strobe: submit the buffer.
- `lock`  in  1  one-cycle strobe: relock from UNLOCKED.
- `clear`  in  1  one-cycle strobe: discard the buffer.
- `hex1`–`hex4`  out  4 each  buffered digits, in entry order (`hex1` is the first digit).
- `counter`  out  3  digits currently buffered, 0–4.
- `state`  out  2  00 INITIAL, 01 UNLOCKED, 10 LOCKED; 11 is never driven.
- `fail`  out  1  one-cycle pulse on a passcode mismatch.
- `lockout`  out  1  high while lockout is active.

## Operation
- All strobes arrive synchronized and debounced. At most one event is honoured per cycle, in priority order: `clear` > `lock` > `enter` > `digit_valid`. Lower-priority strobes in the same cycle are dropped.
- Digit entry:
  - When `counter` < 4, `digit_valid` writes `digit` into `hex[counter+1]` and increments `counter`.
  - When `counter` == 4, further digits are ignored.
- Buffer clear (from `clear` or any state transition): `counter` goes to 0 and `hex1`–`hex4` go to 0.
- `enter` with `counter` < 4 is ignored in every state. It does not clear the buffer and does not pulse `fail`.
- INITIAL, `enter` with 4 digits: passcode is loaded from the buffer; go to LOCKED; clear the buffer.
- LOCKED:
  - `enter` with 4 digits, match: go to UNLOCKED, clear the buffer, zero the fail count.
  - `enter` with 4 digits, mismatch: stay LOCKED, pulse `fail`, clear the buffer, increment the fail count (saturating at `MAX_FAILS`).
  - `lock` is ignored.
- UNLOCKED:
  - `lock`: go to LOCKED, clear the buffer.
  - `enter` with 4 digits: reprogram the passcode from the buffer, stay UNLOCKED, clear the buffer.
- Comparison covers all 16 bits. Digit order matters.

## Timing
- Every output is registered. Each output reflects a strobe on the clock edge that samples it (1-cycle latency).
- `fail` is high for exactly the cycle after the mismatching `enter`.
- Reset values:
  - `state` = 00; `counter` = 0; `hex1`–`hex4` = 0; `fail` = 0; `lockout` = 0.
  - Stored passcode = 0x0000; fail count = 0.
- Reset asserted mid-entry or mid-lockout aborts immediately. The stored passcode is lost.

## Configuration
- `LOCKOUT_EN` defined:
  - When the fail count reaches `MAX_FAILS`, `lockout` rises on the same edge as the final `fail` pulse.
  - While `lockout` is high, all strobes are ignored, and the buffer and `state` (LOCKED) are held.
  - After `LOCKOUT_CYCLES` cycles, `lockout` falls and the fail count returns to 0.
  - `reset` clears lockout.
- `LOCKOUT_EN` undefined:
  - No timer or fail counter is built.
  - The `lockout` port remains and is tied to 0.
  - Unlimited retries.

## Structure
- Shared package `lock_pkg` holds:
  - State encodings `ST_INITIAL` = 2'b00, `ST_UNLOCKED` = 2'b01, `ST_LOCKED` = 2'b10.
  - `CODE_DIGITS` = 4.
  - The blank-digit code 5'b10100 used by the display.
- One sub-module, `lockout_timer`: load/count-down counter with a `busy` output. It is instantiated only under `LOCKOUT_EN`.

## Test plan
- After reset, enter 1,2,3,4 then `enter` → `counter` steps 1–4, then `state` = 10, `counter` = 0, `hex` all 0.
- LOCKED, enter 1,2,3,4 then `enter` → `state` = 01 next cycle, `fail` stays 0. Then `lock` → `state` = 10.
- LOCKED, enter 4,3,2,1 then `enter` → `fail` is a 1-cycle pulse, `state` stays 10, `counter` = 0.
- Enter five digits 1,2,3,4,5 → `counter` = 4, `hex4` = 4. `enter` with 3 digits → no state change. `clear` and `digit_valid` in the same cycle → `counter` = 0.
- `LOCKOUT_EN`, `MAX_FAILS` = 3, `LOCKOUT_CYCLES` = 20:
  - Three mismatches → `lockout` = 1; the correct code is ignored for 20 cycles.
  - After `lockout` falls, the correct code unlocks.
- Assert `reset` with `counter` = 2 in UNLOCKED → all outputs return to their reset values. Then 0,0,0,0 + `enter` programs the new passcode 0x0000.
